// File: rtl/sprite_anim_sequencer.sv
// Walk-cycle animation controller for the player sprite, clocked by vertical sync.
// Picks the sprite-sheet image (idle / walk frames / turn) and pulses on each walk-frame advance.
module sprite_anim_sequencer #(
  parameter logic [7:0] KEY_RIGHT  = 8'd79,
  parameter logic [7:0] KEY_LEFT   = 8'd80,
  parameter int         FRAME_HOLD = 6,
  parameter int         TURN_HOLD  = 3,
  parameter logic [3:0] RIGHT_BASE = 4'd8,
  parameter logic [3:0] LEFT_BASE  = 4'd4,
  parameter logic [3:0] IDLE_R_SEL = 4'd0,
  parameter logic [3:0] IDLE_L_SEL = 4'd1,
  parameter logic [3:0] TURN_SEL   = 4'd12
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] Keycode,
  output logic [3:0] anim_sel,
  output logic       facing_left,
  output logic       walking,
  output logic       step_pulse
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  localparam int HOLD_W = $clog2(FRAME_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_HOLD - 1);

  logic [1:0]        state_q, state_d;
  logic              dir_q, dir_d;
  logic [1:0]        phase_q, phase_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              step_q, step_d;
  logic              fwd, rev;

  // Keys are judged relative to the current facing; in TURN dir has already flipped,
  // so "fwd" there means the key of the new direction.
  assign fwd = (Keycode == (dir_q ? KEY_LEFT : KEY_RIGHT));
  assign rev = (Keycode == (dir_q ? KEY_RIGHT : KEY_LEFT));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fwd) begin
          state_d = WALK;
          phase_d = 2'd0;
          hold_d  = '0;
        end else if (rev) begin
          state_d = TURN;
          dir_d   = ~dir_q;
          turn_d  = '0;
        end
      end
      WALK: begin
        if (fwd) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            phase_d = phase_q + 2'd1;
            step_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else if (rev) begin
          state_d = TURN;
          dir_d   = ~dir_q;
          hold_d  = '0;
          phase_d = 2'd0;
          turn_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
          phase_d = 2'd0;
        end
      end
      TURN: begin
        // Reverse presses here never re-flip dir: only the new-direction key resumes walking.
        if (turn_q != TURN_LAST) begin
          turn_d = turn_q + 1'b1;
        end else if (fwd) begin
          state_d = WALK;
          phase_d = 2'd0;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      phase_q <= 2'd0;
      hold_q  <= '0;
      turn_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    anim_sel = IDLE_R_SEL;
    case (state_q)
      IDLE:    anim_sel = dir_q ? IDLE_L_SEL : IDLE_R_SEL;
      WALK:    anim_sel = (dir_q ? LEFT_BASE : RIGHT_BASE) + {2'b00, phase_q};
      TURN:    anim_sel = TURN_SEL;
      default: anim_sel = IDLE_R_SEL;
    endcase
  end

  assign facing_left = dir_q;
  assign walking     = (state_q == WALK);
  assign step_pulse  = step_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed, table-driven bench for sprite_anim_sequencer with hand-computed expectations.
module tb_sprite_anim_sequencer;

  typedef struct {
    logic [7:0] key;
    logic [3:0] sel;
    logic       fl;
    logic       walk;
    logic       step;
  } vec_t;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b0;
  logic [7:0] Keycode   = 8'd0;
  logic [3:0] anim_sel;
  logic       facing_left;
  logic       walking;
  logic       step_pulse;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  sprite_anim_sequencer dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .Keycode    (Keycode),
    .anim_sel   (anim_sel),
    .facing_left(facing_left),
    .walking    (walking),
    .step_pulse (step_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic addVec(input logic [7:0] k, input logic [3:0] s, input logic f,
                        input logic w, input logic p);
    vec_t v;
    v.key = k; v.sel = s; v.fl = f; v.walk = w; v.step = p;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [7:0] k);
    Keycode = k;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] s, input logic f,
                             input logic w, input logic p);
    checks++;
    if (anim_sel !== s || facing_left !== f || walking !== w || step_pulse !== p) begin
      failures++;
      $display("[TB] FAIL %s: got sel=%0d fl=%0b walk=%0b step=%0b, want sel=%0d fl=%0b walk=%0b step=%0b",
               name, anim_sel, facing_left, walking, step_pulse, s, f, w, p);
    end
  endtask

  initial begin
    // Reset walk-through: 10 idle edges with no key.
    for (int i = 0; i < 10; i++) addVec(8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    // Hold right for 30 edges: advances land on edges 7/13/19/25.
    for (int n = 1; n <= 30; n++) begin
      logic [3:0] s;
      logic       p;
      s = 4'd8;
      if (n >= 7)  s = 4'd9;
      if (n >= 13) s = 4'd10;
      if (n >= 19) s = 4'd11;
      if (n >= 25) s = 4'd8;
      p = (n == 7) || (n == 13) || (n == 19) || (n == 25);
      addVec(8'd79, s, 1'b0, 1'b1, p);
    end
    // Continue to phase 2 (advances at edges 31 and 37).
    addVec(8'd79, 4'd9, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) addVec(8'd79, 4'd9, 1'b0, 1'b1, 1'b0);
    addVec(8'd79, 4'd10, 1'b0, 1'b1, 1'b1);
    // Reverse at phase 2: turn for 3 edges, then walk left from base.
    addVec(8'd80, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd80, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd80, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd80, 4'd4,  1'b1, 1'b1, 1'b0);
    // Release to idle-left, then up-arrow is ignored, then left walks again.
    addVec(8'd0,  4'd1,  1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) addVec(8'd82, 4'd1, 1'b1, 1'b0, 1'b0);
    addVec(8'd80, 4'd4,  1'b1, 1'b1, 1'b0);
    // Turn back to the right and walk up to phase 3.
    addVec(8'd79, 4'd12, 1'b0, 1'b0, 1'b0);
    addVec(8'd79, 4'd12, 1'b0, 1'b0, 1'b0);
    addVec(8'd79, 4'd12, 1'b0, 1'b0, 1'b0);
    addVec(8'd79, 4'd8,  1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      logic [3:0] s;
      s = 4'd8;
      if (k >= 6)  s = 4'd9;
      if (k >= 12) s = 4'd10;
      if (k >= 18) s = 4'd11;
      addVec(8'd79, s, 1'b0, 1'b1, (k == 6) || (k == 12) || (k == 18));
    end
    // Stop at phase 3, restart: phase and hold both start over.
    addVec(8'd0,  4'd0, 1'b0, 1'b0, 1'b0);
    addVec(8'd79, 4'd8, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) addVec(8'd79, 4'd8, 1'b0, 1'b1, 1'b0);
    addVec(8'd79, 4'd9, 1'b0, 1'b1, 1'b1);
    // Reverse into TURN, then press the old direction: dir stays left, ends in IDLE.
    addVec(8'd80, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd79, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd79, 4'd12, 1'b1, 1'b0, 1'b0);
    addVec(8'd79, 4'd1,  1'b1, 1'b0, 1'b0);

    Reset_n = 1'b0;
    Keycode = 8'd0;
    #12;
    checkOutput("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].key);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].fl, vecs[i].walk, vecs[i].step);
    end

    // Async reset mid-TURN: from idle-left turn right, walk, then turn left again.
    applyStimulus(8'd79);
    checkOutput("turn_r_enter", 4'd12, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd79);
    applyStimulus(8'd79);
    applyStimulus(8'd79);
    checkOutput("turn_r_walk", 4'd8, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd80);
    checkOutput("turn_l_enter", 4'd12, 1'b1, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_turn", 4'd0, 1'b0, 1'b0, 1'b0);
    Keycode = 8'd0;
    @(negedge frame_clk);
    Reset_n = 1'b1;
    applyStimulus(8'd0);
    checkOutput("after_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Async reset right after a step pulse must clear it immediately.
    applyStimulus(8'd79);
    for (int i = 0; i < 6; i++) applyStimulus(8'd79);
    checkOutput("pulse_before_reset", 4'd9, 1'b0, 1'b1, 1'b1);
    Reset_n = 1'b0;
    #1;
    checkOutput("async_reset_clears_pulse", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
